mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADX_W, default 11, request address width in word units.
REQ-002 Parameter DEPTH, default 128, number of implemented 32-bit words (addresses 0..DEPTH-1).
REQ-003 Parameter WAIT_CYCLES, default 2, wait states between request acceptance and response (0..15).
REQ-004 SysCLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SysRST  input  1  asynchronous, active-low reset.
REQ-006 ReqValid  input  1  initiator presents a request.
REQ-007 ReqRNW  input  1  1 = read, 0 = write.
REQ-008 ReqAdx  input  ADX_W  word address.
REQ-009 ReqWD  input  32  write data.
REQ-010 ReqReady  output  1  responder can accept a request this cycle.
REQ-011 RspValid  output  1  response available.
REQ-012 RspRD  output  32  read data; 0 for writes and errors.
REQ-013 RspErr  output  1  request address was >= DEPTH.
REQ-014 RspReady  input  1  initiator accepts the response this cycle.

Function
REQ-015 Three-state FSM: IDLE, WAIT, RESP; ReqReady SHALL be 1 only in IDLE.
REQ-016 IDLE: a request is accepted when ReqValid && ReqReady; ReqRNW, ReqAdx and ReqWD are captured; next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-017 WAIT: wait counter loads WAIT_CYCLES-1 on acceptance, decrements each cycle, and moves to RESP on the cycle it reads 0; total accept-to-RspValid latency is WAIT_CYCLES+1 cycles.
REQ-018 A write to an in-range address SHALL update storage on the clock edge that enters RESP.
REQ-019 A read SHALL register RspRD from storage on the edge entering RESP, so a read issued after a write's response returns the new data.
REQ-020 Out-of-range address: no storage update; RspErr=1 and RspRD=0 in RESP.
REQ-021 RESP: RspValid, RspRD and RspErr SHALL stay stable until RspReady=1; on that edge the FSM returns to IDLE and RspValid, RspErr and RspRD clear.
REQ-022 ReqValid while not in IDLE SHALL be ignored, with no capture or side effect; the initiator holds the request until ReqReady.
REQ-023 The RESP-to-IDLE transition SHALL NOT accept a request on the same edge; the earliest next acceptance is the cycle after RspValid falls (one idle-ready cycle minimum).
REQ-024 Address comparison SHALL use the full ADX_W bits; there is no aliasing or wrap-around.

Reset
REQ-025 While SysRST=0: FSM=IDLE, wait counter=0, ReqReady=1, RspValid=0, RspErr=0, RspRD=0, and captured request registers=0.
REQ-026 Storage contents are not reset and are undefined until written.
REQ-027 Reset asserted in WAIT or RESP SHALL abort the transaction; a pending write that has not reached RESP SHALL NOT modify storage.

Structure
REQ-028 The shared package SHALL hold the FSM state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10), the DATA_W=32 constant, and the maximum WAIT_CYCLES constant (15).
REQ-029 The storage SHALL be one sub-module, mem_array, with a synchronous write port and a registered read port, DEPTH x 32 bits.
REQ-030 The FSM, wait counter and range check SHALL reside in mem_responder.

Verification
REQ-031 Bench (WAIT_CYCLES=2, RspReady=1): write 0xDEADBEEF to address 5, then read address 5 -> read RspValid rises 3 cycles after acceptance with RspRD=0xDEADBEEF and RspErr=0.
REQ-032 Read address 200 (DEPTH=128) -> RspErr=1 and RspRD=0; a following read of address 72 (200 mod 128) returns its prior value, unchanged.
REQ-033 Hold RspReady=0 for 5 cycles in RESP -> RspValid, RspRD and RspErr stay stable and ReqReady=0; a ReqValid pulse in this window is not accepted.
REQ-034 Write 0x12345678 to address 9, assert SysRST during WAIT, then write and read back 0x0 at address 9 -> RspRD=0x0; separately, after 0x0 is written to address 9, an aborted write of 0xFFFFFFFF followed by a read returns 0x0.
REQ-035 WAIT_CYCLES=0 with back-to-back requests -> RspValid 1 cycle after acceptance, and ReqReady low for exactly 1 cycle between two ready cycles when RspReady=1 throughout.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
// Holds the FSM encoding, data width and the address range helper.
package mem_responder_pkg;

    localparam int DATA_W          = 32;
    localparam int MAX_WAIT_CYCLES = 15;
    localparam int WAIT_CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Full-width compare: addresses at or beyond depth never alias into storage.
    function automatic logic adx_in_range(input logic [31:0] adx, input int depth);
        return (adx < 32'(depth));
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 storage with a synchronous write port and a registered read port.
// The read register can be cleared so it doubles as the response data register.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wd;
        end
    end

    // Read data register: a load takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= {DATA_W{1'b0}};
        end else if (re) begin
            rd <= mem_r[addr];
        end else if (clr) begin
            rd <= {DATA_W{1'b0}};
        end else begin
            rd <= rd;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with configurable wait states.
// The FSM, wait counter and address range check live here; storage is in mem_array.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADX_W       = 11,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              SysCLK,
    input  logic              SysRST,
    input  logic              ReqValid,
    input  logic              ReqRNW,
    input  logic [ADX_W-1:0]  ReqAdx,
    input  logic [DATA_W-1:0] ReqWD,
    output logic              ReqReady,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspRD,
    output logic              RspErr,
    input  logic              RspReady
);

    localparam int MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit NO_WAIT_C = (WAIT_CYCLES == 0);

    state_t                  state_r;
    logic [WAIT_CNT_W-1:0]   wait_cnt_r;
    logic                    rnw_r;
    logic [ADX_W-1:0]        adx_r;
    logic [DATA_W-1:0]       wd_r;

    logic                    accept_s;
    logic                    enter_resp_s;
    logic                    op_rnw_s;
    logic [ADX_W-1:0]        op_adx_s;
    logic [DATA_W-1:0]       op_wd_s;
    logic                    in_range_s;
    logic                    mem_we_s;
    logic                    mem_re_s;
    logic                    mem_clr_s;

    assign accept_s = ReqValid && ReqReady;

    // With zero wait states the operation enters RESP straight from the live request.
    always_comb begin
        op_rnw_s = rnw_r;
        op_adx_s = adx_r;
        op_wd_s  = wd_r;
        if (state_r == ST_IDLE) begin
            op_rnw_s = ReqRNW;
            op_adx_s = ReqAdx;
            op_wd_s  = ReqWD;
        end else begin
            op_rnw_s = rnw_r;
            op_adx_s = adx_r;
            op_wd_s  = wd_r;
        end
    end

    // Detect the edge that enters RESP and derive the storage strobes from it.
    always_comb begin
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: enter_resp_s = accept_s && NO_WAIT_C;
            ST_WAIT: enter_resp_s = (wait_cnt_r == {WAIT_CNT_W{1'b0}});
            default: enter_resp_s = 1'b0;
        endcase
        in_range_s = adx_in_range(32'(op_adx_s), DEPTH);
        mem_we_s   = enter_resp_s && !op_rnw_s && in_range_s;
        mem_re_s   = enter_resp_s && op_rnw_s && in_range_s;
        mem_clr_s  = (enter_resp_s && !(op_rnw_s && in_range_s)) ||
                     ((state_r == ST_RESP) && RspReady);
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge SysCLK or negedge SysRST) begin
        if (!SysRST) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
            rnw_r      <= 1'b0;
            adx_r      <= {ADX_W{1'b0}};
            wd_r       <= {DATA_W{1'b0}};
            ReqReady   <= 1'b1;
            RspValid   <= 1'b0;
            RspErr     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        rnw_r    <= ReqRNW;
                        adx_r    <= ReqAdx;
                        wd_r     <= ReqWD;
                        ReqReady <= 1'b0;
                        if (NO_WAIT_C) begin
                            state_r  <= ST_RESP;
                            RspValid <= 1'b1;
                            RspErr   <= !in_range_s;
                        end else begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= WAIT_CNT_W'(WAIT_CYCLES - 1);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == {WAIT_CNT_W{1'b0}}) begin
                        state_r  <= ST_RESP;
                        RspValid <= 1'b1;
                        RspErr   <= !in_range_s;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Going back to IDLE never accepts on the same edge; ReqReady rises here.
                    if (RspReady) begin
                        state_r  <= ST_IDLE;
                        RspValid <= 1'b0;
                        RspErr   <= 1'b0;
                        ReqReady <= 1'b1;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= {WAIT_CNT_W{1'b0}};
                    ReqReady   <= 1'b1;
                    RspValid   <= 1'b0;
                    RspErr     <= 1'b0;
                end
            endcase
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (MEM_AW)
    ) u_mem_array (
        .clk   (SysCLK),
        .rst_n (SysRST),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .clr   (mem_clr_s),
        .addr  (op_adx_s[MEM_AW-1:0]),
        .wd    (op_wd_s),
        .rd    (RspRD)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
// A second instance with zero wait states covers back-to-back handshaking.
module tb_mem_responder;

    localparam int ADX_W = 11;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_rnw, req_ready, rsp_valid, rsp_err, rsp_ready;
    logic [10:0] req_adx;
    logic [31:0] req_wd, rsp_rd;
    logic        z_valid, z_rnw, z_ready, z_rsp_valid, z_rsp_err, z_rsp_ready;
    logic [10:0] z_adx;
    logic [31:0] z_wd, z_rsp_rd;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model  [DEPTH];
    bit          known  [DEPTH];
    logic [31:0] model0 [DEPTH];

    always #5 clk = ~clk;

    mem_responder #(.ADX_W(ADX_W), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut (
        .SysCLK(clk), .SysRST(rst_n), .ReqValid(req_valid), .ReqRNW(req_rnw),
        .ReqAdx(req_adx), .ReqWD(req_wd), .ReqReady(req_ready), .RspValid(rsp_valid),
        .RspRD(rsp_rd), .RspErr(rsp_err), .RspReady(rsp_ready)
    );

    mem_responder #(.ADX_W(ADX_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_nowait (
        .SysCLK(clk), .SysRST(rst_n), .ReqValid(z_valid), .ReqRNW(z_rnw),
        .ReqAdx(z_adx), .ReqWD(z_wd), .ReqReady(z_ready), .RspValid(z_rsp_valid),
        .RspRD(z_rsp_rd), .RspErr(z_rsp_err), .RspReady(z_rsp_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction on the 2-wait-state instance, optionally stalling the response.
    task automatic do_txn(input bit rnw, input logic [10:0] adx, input logic [31:0] wd,
                          input int hold, input bit pulse);
        int          n;
        bit          inr;
        bit          chk_rd;
        logic [31:0] exp_rd;
        inr    = (int'(adx) < DEPTH);
        exp_rd = 32'h0;
        chk_rd = 1'b1;
        if (rnw && inr) begin
            exp_rd = model[adx];
            chk_rd = known[adx];
        end
        @(negedge clk);
        req_valid = 1'b1; req_rnw = rnw; req_adx = adx; req_wd = wd;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check_eq("ready_before_accept", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check_eq("accept_to_rspvalid", n, 32'd3);
        check_eq("rsp_err", {31'h0, rsp_err}, {31'h0, !inr});
        if (chk_rd) check_eq("rsp_rd", rsp_rd, exp_rd);
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) begin
                req_valid = 1'b1; req_rnw = 1'b0; req_adx = adx; req_wd = ~wd;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            check_eq("hold_rspvalid", {31'h0, rsp_valid}, 32'h1);
            check_eq("hold_reqready", {31'h0, req_ready}, 32'h0);
            check_eq("hold_rsp_err", {31'h0, rsp_err}, {31'h0, !inr});
            if (chk_rd) check_eq("hold_rsp_rd", rsp_rd, exp_rd);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("after_rsp_idle", {28'h0, rsp_valid, rsp_err, req_ready, 1'b0}, 32'h2);
        check_eq("after_rsp_rd", rsp_rd, 32'h0);
        if (!rnw && inr) begin
            model[adx] = wd;
            known[adx] = 1'b1;
        end
    endtask

    // Write that is killed by reset while still waiting.
    task automatic abort_write(input logic [10:0] adx, input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_rnw = 1'b0; req_adx = adx; req_wd = wd; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("abort_in_wait", {30'h0, rsp_valid, req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("abort_reset_state", {29'h0, req_ready, rsp_valid, rsp_err}, 32'h4);
        check_eq("abort_reset_rd", rsp_rd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          rnw;
        logic [10:0] adx;
        logic [31:0] wd;
        int          hold;
        logic [10:0] z_adx_tbl [6];
        logic [31:0] z_exp;
        bit          z_inr;

        rst_n = 1'b0;
        req_valid = 1'b0; req_rnw = 1'b0; req_adx = 11'h0; req_wd = 32'h0; rsp_ready = 1'b1;
        z_valid = 1'b0; z_rnw = 1'b0; z_adx = 11'h0; z_wd = 32'h0; z_rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {29'h0, req_ready, rsp_valid, rsp_err}, 32'h4);
        check_eq("reset_rd", rsp_rd, 32'h0);
        check_eq("reset_nowait_ready", {31'h0, z_ready}, 32'h1);
        rst_n = 1'b1;

        do_txn(1'b0, 11'd5, 32'hDEADBEEF, 0, 1'b0);
        do_txn(1'b1, 11'd5, 32'h0, 0, 1'b0);
        do_txn(1'b0, 11'd72, 32'hA5A50072, 0, 1'b0);
        do_txn(1'b1, 11'd200, 32'h0, 0, 1'b0);
        do_txn(1'b1, 11'd72, 32'h0, 0, 1'b0);
        do_txn(1'b0, 11'd127, 32'h0000007F, 0, 1'b0);
        do_txn(1'b0, 11'd128, 32'hBAD00080, 0, 1'b0);
        do_txn(1'b1, 11'd127, 32'h0, 0, 1'b0);
        do_txn(1'b1, 11'd2047, 32'h0, 0, 1'b0);
        do_txn(1'b1, 11'd0, 32'h0, 0, 1'b0);
        do_txn(1'b1, 11'd5, 32'h0, 5, 1'b1);
        do_txn(1'b1, 11'd5, 32'h0, 0, 1'b0);

        abort_write(11'd9, 32'h12345678);
        do_txn(1'b0, 11'd9, 32'h0, 0, 1'b0);
        do_txn(1'b1, 11'd9, 32'h0, 0, 1'b0);
        abort_write(11'd9, 32'hFFFFFFFF);
        do_txn(1'b1, 11'd9, 32'h0, 0, 1'b0);

        for (int k = 0; k < 120; k++) begin
            rnw  = 1'($urandom_range(0, 1));
            adx  = ($urandom_range(0, 3) != 0) ? 11'($urandom_range(0, DEPTH - 1))
                                               : 11'($urandom_range(0, 2047));
            wd   = $urandom;
            hold = $urandom_range(0, 3);
            do_txn(rnw, adx, wd, hold, (hold >= 2) && ($urandom_range(0, 1) == 1));
        end

        // Zero wait states, ReqValid held high throughout.
        z_adx_tbl[0] = 11'd3;   z_adx_tbl[1] = 11'd3;
        z_adx_tbl[2] = 11'd130; z_adx_tbl[3] = 11'd130;
        z_adx_tbl[4] = 11'd127; z_adx_tbl[5] = 11'd127;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check_eq("nowait_ready_idle", {31'h0, z_ready}, 32'h1);
            z_valid = 1'b1;
            z_rnw   = k[0];
            z_adx   = z_adx_tbl[k];
            z_wd    = $urandom;
            z_inr   = (int'(z_adx) < DEPTH);
            z_exp   = (z_rnw && z_inr) ? model0[z_adx] : 32'h0;
            if (!z_rnw && z_inr) model0[z_adx] = z_wd;
            @(negedge clk);
            check_eq("nowait_rspvalid", {31'h0, z_rsp_valid}, 32'h1);
            check_eq("nowait_ready_low", {31'h0, z_ready}, 32'h0);
            check_eq("nowait_err", {31'h0, z_rsp_err}, {31'h0, !z_inr});
            check_eq("nowait_rd", z_rsp_rd, z_exp);
            @(negedge clk);
            check_eq("nowait_rsp_drop", {31'h0, z_rsp_valid}, 32'h0);
        end
        z_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
